vp_cfg_sched: RTL
=================

Name: vp_cfg_sched

Overview:
- Frame-synchronous configuration scheduler for the video-process (VP) chain: cutter -> filter -> scaler -> colour/edge/binarizer -> filler.
- Captures software writes of VP_CR/VP_START/VP_END/VP_SCALER into a pending set. Validates the set and commits it only at a frame boundary (vs rising edge), so no stage sees a mid-frame change.
- Derives the scaler "resolution minus 1" values. Mutes the output for a programmable number of frames after each commit so pipelines and line buffers flush.

Parameters:
- H_DISP, 1280, maximum input/output width in pixels.
- V_DISP, 720, maximum input/output height in lines.
- X_W, 11, width of X coordinate and resolution fields.
- Y_W, 11, width of Y coordinate and resolution fields.
- FLUSH_FRAMES, 2, frames of mute after a commit (1..15).

Ports:
- clk  in  1  VP clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_wr  in  1  one-cycle strobe; the four cfg_* words are valid.
- cfg_cr  in  32  [31:30] filler_mode, [6] binarizer_en, [5] edge_en, [4] color_en, [3] scaler_en, [2] cutter_en, [1:0] filter_mode, [15:8] threshold.
- cfg_start  in  32  [X_W-1:0] START_X, [16+Y_W-1:16] START_Y.
- cfg_end  in  32  [X_W-1:0] END_X, [16+Y_W-1:16] END_Y.
- cfg_scaler  in  32  [X_W-1:0] OUT_X, [16+Y_W-1:16] OUT_Y.
- vs_in  in  1  frame vsync, already synchronous to clk.
- act_cr  out  32  committed VP_CR.
- start_x/start_y, end_x/end_y  out  X_W/Y_W  committed crop window.
- in_x_res/in_y_res  out  X_W/Y_W  END-START-1.
- out_x_res/out_y_res  out  X_W/Y_W  OUT-1.
- filler_en  out  1  filler_mode==00 and OUT_X<H_DISP.
- mute  out  1  downstream must force de=0.
- status  out  32  [0] pending, [1] err_sticky, [2] mute, [3] busy (state!=IDLE), [7:4] flush count remaining, [31:16] commit counter.

Behaviour:
- Reset values:
  - act_cr = 0xC000_0008 (filler bypass, scaler_en).
  - START = 0, END = H_DISP/V_DISP, OUT = H_DISP/V_DISP.
  - in_x_res = H_DISP-1, in_y_res = V_DISP-1, out_x_res = H_DISP-1, out_y_res = V_DISP-1.
  - filler_en = 0, mute = 0, status = 0, state IDLE.
- vs edge detect: vs_q registered each cycle; vs_rise = vs_in & ~vs_q. A vs high at reset release is not an edge.
- cfg_wr: latch all four words into pending regs and set pending=1 next cycle, in any state.
- Validation is combinational on pending. valid = START_X<END_X<=H_DISP, START_Y<END_Y<=V_DISP, 1<=OUT_X<=H_DISP, 1<=OUT_Y<=V_DISP.
- States:
  - IDLE: on vs_rise with pending -> APPLY.
  - APPLY (1 cycle):
    - If valid: copy pending into active regs, register the derived outputs, increment the commit counter (wraps at 0xFFFF), load flush_cnt=FLUSH_FRAMES, set mute, -> FLUSH.
    - If invalid: set err_sticky, keep the active set, -> IDLE.
    - In both cases clear pending, unless cfg_wr is high in that same cycle; the new write wins and pending stays 1.
  - FLUSH: each vs_rise decrements flush_cnt. On reaching 0, clear mute -> IDLE. A vs_rise with a new pending while in FLUSH does not commit; it waits for the first vs_rise in IDLE.
- Latency: active outputs and mute change exactly 2 cycles after the vs_in rising sample (edge detect + APPLY).
- Derived arithmetic is modulo the field width. Validation guarantees END>START and OUT>=1, so no underflow on committed values.
- err_sticky clears only on reset or on the next valid commit.
- Repeated cfg_wr before a frame boundary: the last write wins.

Decomposition:
- Package vp_pkg holds:
  - Field bit positions for CR/START/END/SCALER.
  - Filler-mode constants (FILL_SCALER=00, FILL_EDGE=01, FILL_BIN=10, FILL_BYPASS=11).
  - Filter-mode constants.
  - State enum {IDLE, APPLY, FLUSH}.
  - Reset default word constants.
- One sub-module: vp_cfg_check, the combinational validator returning valid and the four derived res-1 values. It is reused by the driver-side register model.

Test Plan:
- Reset, no writes -> outputs equal reset values: in_x_res=1279, out_x_res=1279, act_cr=0xC000_0008, mute=0, status=0.
- Downscale commit:
  - Stimulus: write START=0, END=(720<<16)|1280, SCALER=(360<<16)|640, CR=0x0000_0008, then vs pulse.
  - Required: out_x_res=639, out_y_res=359, filler_en=1, 2 cycles after the vs sample; mute high for exactly 2 vs edges; commit counter=1.
- Invalid window: write START_X=800, END_X=400, then vs -> active set unchanged, status[1]=1, mute stays 0, pending=0.
- Double write mid-frame:
  - Stimulus: write OUT_X=640 then OUT_X=320 before vs.
  - Required: only 320 commits (out_x_res=319); counter increments by 1.
- Write during FLUSH: write a valid set while mute=1 -> no commit until the first vs after mute clears; pending=1 throughout.
- Async reset mid-FLUSH: assert rst between vs edges -> all outputs return to reset values immediately, without waiting for a clk edge; state IDLE, pending=0.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared definitions for the video-process configuration scheduler:
// VP_CR field layout, coordinate field positions, mode encodings, FSM states
// and reset defaults.
package vp_pkg;

  // Bit position of the X and Y fields inside VP_START/VP_END/VP_SCALER.
  localparam int FIELD_X_LSB = 0;
  localparam int FIELD_Y_LSB = 16;

  // Filler source select, VP_CR[31:30].
  typedef enum logic [1:0] {
    FILL_SCALER = 2'b00,
    FILL_EDGE   = 2'b01,
    FILL_BIN    = 2'b10,
    FILL_BYPASS = 2'b11
  } filler_mode_e;

  // Pre-filter select, VP_CR[1:0].
  typedef enum logic [1:0] {
    FILT_BYPASS = 2'b00,
    FILT_MEAN   = 2'b01,
    FILT_MEDIAN = 2'b10,
    FILT_GAUSS  = 2'b11
  } filter_mode_e;

  // VP_CR layout, MSB first.
  typedef struct packed {
    filler_mode_e filler_mode;  // [31:30]
    logic [13:0]  rsvd_hi;      // [29:16]
    logic [7:0]   threshold;    // [15:8]
    logic         rsvd_lo;      // [7]
    logic         binarizer_en; // [6]
    logic         edge_en;      // [5]
    logic         color_en;     // [4]
    logic         scaler_en;    // [3]
    logic         cutter_en;    // [2]
    filter_mode_e filter_mode;  // [1:0]
  } vp_cr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Filler bypassed, scaler enabled, everything else off.
  localparam logic [31:0] CR_RESET = 32'hC000_0008;

endpackage

// File: rtl/vp_cfg_check.sv
// Combinational validator for a VP configuration set. Reports whether the
// crop window and scaler output size are legal and produces the
// "resolution minus 1" values each stage is programmed with.
module vp_cfg_check
  import vp_pkg::*;
#(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
) (
  input  logic [X_W-1:0] start_x_i,
  input  logic [Y_W-1:0] start_y_i,
  input  logic [X_W-1:0] end_x_i,
  input  logic [Y_W-1:0] end_y_i,
  input  logic [X_W-1:0] out_x_i,
  input  logic [Y_W-1:0] out_y_i,
  output logic           valid_o,
  output logic [X_W-1:0] in_x_res_o,
  output logic [Y_W-1:0] in_y_res_o,
  output logic [X_W-1:0] out_x_res_o,
  output logic [Y_W-1:0] out_y_res_o
);

  localparam logic [X_W-1:0] H_MAX = X_W'(H_DISP);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_DISP);

  logic win_ok;
  logic out_ok;

  // Window must be non-empty and inside the frame; output size 1..max.
  always_comb begin
    win_ok  = (start_x_i < end_x_i) && (end_x_i <= H_MAX) &&
              (start_y_i < end_y_i) && (end_y_i <= V_MAX);
    out_ok  = (out_x_i != '0) && (out_x_i <= H_MAX) &&
              (out_y_i != '0) && (out_y_i <= V_MAX);
    valid_o = win_ok && out_ok;
  end

  // Derived values wrap at the field width; a valid set never underflows.
  always_comb begin
    in_x_res_o  = end_x_i - start_x_i - X_W'(1);
    in_y_res_o  = end_y_i - start_y_i - Y_W'(1);
    out_x_res_o = out_x_i - X_W'(1);
    out_y_res_o = out_y_i - Y_W'(1);
  end

endmodule

// File: rtl/vp_cfg_sched.sv
// Frame-synchronous configuration scheduler for the VP chain. Software writes
// land in a pending set; the set is validated and committed to the active
// registers only on a vsync rising edge, then the output is muted for a
// number of frames so downstream pipelines and line buffers can flush.
module vp_cfg_sched
  import vp_pkg::*;
#(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int X_W          = 11,
  parameter int Y_W          = 11,
  parameter int FLUSH_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_wr,
  input  logic [31:0]    cfg_cr,
  input  logic [31:0]    cfg_start,
  input  logic [31:0]    cfg_end,
  input  logic [31:0]    cfg_scaler,
  input  logic           vs_in,
  output logic [31:0]    act_cr,
  output logic [X_W-1:0] start_x,
  output logic [Y_W-1:0] start_y,
  output logic [X_W-1:0] end_x,
  output logic [Y_W-1:0] end_y,
  output logic [X_W-1:0] in_x_res,
  output logic [Y_W-1:0] in_y_res,
  output logic [X_W-1:0] out_x_res,
  output logic [Y_W-1:0] out_y_res,
  output logic           filler_en,
  output logic           mute,
  output logic [31:0]    status
);

  localparam logic [X_W-1:0] H_MAX     = X_W'(H_DISP);
  localparam logic [Y_W-1:0] V_MAX     = Y_W'(V_DISP);
  localparam logic [3:0]     FLUSH_CNT = 4'(FLUSH_FRAMES);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;

  logic            vs_q, vs_rise_q;

  vp_cr_t          pend_cr_q;
  logic [X_W-1:0]  pend_sx_q, pend_ex_q, pend_ox_q;
  logic [Y_W-1:0]  pend_sy_q, pend_ey_q, pend_oy_q;
  logic            pending_q, pending_d;

  vp_cr_t          act_cr_q;
  logic [X_W-1:0]  act_sx_q, act_ex_q, in_x_res_q, out_x_res_q;
  logic [Y_W-1:0]  act_sy_q, act_ey_q, in_y_res_q, out_y_res_q;
  logic            filler_en_q;

  logic            mute_q, mute_d;
  logic            err_q, err_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic [15:0]     commit_cnt_q, commit_cnt_d;

  logic            commit, reject, flush_dec, flush_last;

  logic            chk_valid;
  logic [X_W-1:0]  chk_in_x_res, chk_out_x_res;
  logic [Y_W-1:0]  chk_in_y_res, chk_out_y_res;

  // Register fields outside the X/Y coordinate slices carry no meaning.
  logic            unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_start[31:FIELD_Y_LSB+Y_W],
                             cfg_start[FIELD_Y_LSB-1:FIELD_X_LSB+X_W],
                             cfg_end[31:FIELD_Y_LSB+Y_W],
                             cfg_end[FIELD_Y_LSB-1:FIELD_X_LSB+X_W],
                             cfg_scaler[31:FIELD_Y_LSB+Y_W],
                             cfg_scaler[FIELD_Y_LSB-1:FIELD_X_LSB+X_W]};

  // ---------------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------------
  // Registered vsync rising-edge pulse; vs_q resets high so a vsync already
  // asserted at reset release is not mistaken for a new frame.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q      <= 1'b1;
      vs_rise_q <= 1'b0;
    end else begin
      vs_q      <= vs_in;
      vs_rise_q <= vs_in & ~vs_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending set: every write overwrites it, so the last write before a frame
  // boundary wins.
  // ---------------------------------------------------------------------------
  // Capture the four configuration words on each software strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cr_q <= '0;
      pend_sx_q <= '0;
      pend_sy_q <= '0;
      pend_ex_q <= '0;
      pend_ey_q <= '0;
      pend_ox_q <= '0;
      pend_oy_q <= '0;
    end else if (cfg_wr) begin
      pend_cr_q <= vp_cr_t'(cfg_cr);
      pend_sx_q <= cfg_start[FIELD_X_LSB +: X_W];
      pend_sy_q <= cfg_start[FIELD_Y_LSB +: Y_W];
      pend_ex_q <= cfg_end[FIELD_X_LSB +: X_W];
      pend_ey_q <= cfg_end[FIELD_Y_LSB +: Y_W];
      pend_ox_q <= cfg_scaler[FIELD_X_LSB +: X_W];
      pend_oy_q <= cfg_scaler[FIELD_Y_LSB +: Y_W];
    end
  end

  vp_cfg_check #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_check (
    .start_x_i   (pend_sx_q),
    .start_y_i   (pend_sy_q),
    .end_x_i     (pend_ex_q),
    .end_y_i     (pend_ey_q),
    .out_x_i     (pend_ox_q),
    .out_y_i     (pend_oy_q),
    .valid_o     (chk_valid),
    .in_x_res_o  (chk_in_x_res),
    .in_y_res_o  (chk_in_y_res),
    .out_x_res_o (chk_out_x_res),
    .out_y_res_o (chk_out_y_res)
  );

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: commit only from IDLE; a new set arriving during FLUSH waits
  // for the first frame boundary after the flush completes.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vs_rise_q && pending_q) state_d = APPLY;
      APPLY:   state_d = chk_valid ? FLUSH : IDLE;
      FLUSH:   if (vs_rise_q && (flush_cnt_q == 4'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: single-cycle commit/reject decisions and flush countdown.
  always_comb begin
    commit    = 1'b0;
    reject    = 1'b0;
    flush_dec = 1'b0;
    unique case (state_q)
      APPLY: begin
        commit = chk_valid;
        reject = ~chk_valid;
      end
      FLUSH:   flush_dec = vs_rise_q;
      default: ;
    endcase
  end

  assign flush_last = flush_dec && (flush_cnt_q == 4'd1);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // Next values for pending/mute/error/counters; a write in the APPLY cycle
  // takes priority over the clear so that write is not lost.
  always_comb begin
    pending_d    = pending_q;
    mute_d       = mute_q;
    err_d        = err_q;
    flush_cnt_d  = flush_cnt_q;
    commit_cnt_d = commit_cnt_q;

    if (state_q == APPLY) pending_d = 1'b0;
    if (cfg_wr)           pending_d = 1'b1;

    if (commit) begin
      mute_d       = 1'b1;
      err_d        = 1'b0;
      flush_cnt_d  = FLUSH_CNT;
      commit_cnt_d = commit_cnt_q + 16'd1;
    end else if (flush_dec) begin
      flush_cnt_d = flush_cnt_q - 4'd1;
      if (flush_last) mute_d = 1'b0;
    end

    if (reject) err_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      mute_q       <= 1'b0;
      err_q        <= 1'b0;
      flush_cnt_q  <= '0;
      commit_cnt_q <= '0;
    end else begin
      pending_q    <= pending_d;
      mute_q       <= mute_d;
      err_q        <= err_d;
      flush_cnt_q  <= flush_cnt_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Active set: loaded only on a validated commit.
  // ---------------------------------------------------------------------------
  // Copy the pending set and its derived values into the active registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_cr_q    <= vp_cr_t'(CR_RESET);
      act_sx_q    <= '0;
      act_sy_q    <= '0;
      act_ex_q    <= H_MAX;
      act_ey_q    <= V_MAX;
      in_x_res_q  <= H_MAX - X_W'(1);
      in_y_res_q  <= V_MAX - Y_W'(1);
      out_x_res_q <= H_MAX - X_W'(1);
      out_y_res_q <= V_MAX - Y_W'(1);
      filler_en_q <= 1'b0;
    end else if (commit) begin
      act_cr_q    <= pend_cr_q;
      act_sx_q    <= pend_sx_q;
      act_sy_q    <= pend_sy_q;
      act_ex_q    <= pend_ex_q;
      act_ey_q    <= pend_ey_q;
      in_x_res_q  <= chk_in_x_res;
      in_y_res_q  <= chk_in_y_res;
      out_x_res_q <= chk_out_x_res;
      out_y_res_q <= chk_out_y_res;
      filler_en_q <= (pend_cr_q.filler_mode == FILL_SCALER) && (pend_ox_q < H_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign act_cr    = act_cr_q;
  assign start_x   = act_sx_q;
  assign start_y   = act_sy_q;
  assign end_x     = act_ex_q;
  assign end_y     = act_ey_q;
  assign in_x_res  = in_x_res_q;
  assign in_y_res  = in_y_res_q;
  assign out_x_res = out_x_res_q;
  assign out_y_res = out_y_res_q;
  assign filler_en = filler_en_q;
  assign mute      = mute_q;
  assign status    = {commit_cnt_q, 8'h00, flush_cnt_q,
                      (state_q != IDLE), mute_q, err_q, pending_q};

endmodule
